// File: rtl/rs232_rx_if.sv
// Valid/ready byte stream from the UART receiver to the command/telemetry consumer.
// The receiver drives the master side; the consumer drives rx_ready.
interface rs232_rx_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;

    modport master (output rx_data, output rx_valid, input rx_ready);
    modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/rs232_rx.sv
// 8N1 UART receiver: 16x oversampling with 3-sample majority vote per bit,
// followed by a small FIFO that feeds a valid/ready byte stream.
module rs232_rx #(
    parameter int CLK_HZ     = 48_000_000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          rx232,
    rs232_rx_if.master                    rx_if,
    output logic                          frame_err,
    output logic                          overrun,
    output logic                          rx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int DIV = CLK_HZ / (BAUD * 16);
    localparam int PW  = $clog2(DIV) + 1;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int LW  = AW + 1;

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

    logic          s1_q, s2_q, prev_q, armed_q;
    logic [1:0]    warm_q;
    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [3:0]    tcnt_q, tcnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [1:0]    samp_q, samp_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [LW-1:0] level_q, level_d, remain;
    logic [7:0]    rx_data_q, rx_data_d;
    logic          rx_valid_q, ferr_q, ferr_d, ovr_q, ovr_d, busy_q;
    logic          tick, fall, decide, maj, push_req, do_push, do_pop, full;

    always_comb begin
        tick     = (presc_q == PW'(DIV - 1));
        fall     = armed_q & prev_q & ~s2_q;
        decide   = tick & (tcnt_q == 4'd9);
        maj      = (samp_q[0] & samp_q[1]) | (samp_q[0] & s2_q) | (samp_q[1] & s2_q);
        state_d  = state_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        samp_d   = samp_q;
        push_req = 1'b0;
        ferr_d   = 1'b0;
        presc_d  = tick ? '0 : presc_q + PW'(1);
        tcnt_d   = tick ? tcnt_q + 4'd1 : tcnt_q;
        if (tick && tcnt_q == 4'd7) samp_d[0] = s2_q;
        if (tick && tcnt_q == 4'd8) samp_d[1] = s2_q;

        case (state_q)
            IDLE:  if (fall) state_d = START;
            START: if (decide) begin
                       state_d = maj ? IDLE : DATA;
                       bit_d   = '0;
                   end
            DATA:  if (decide) begin
                       shift_d = {maj, shift_q[7:1]};
                       bit_d   = bit_q + 3'd1;
                       if (bit_q == 3'd7) state_d = STOP;
                   end
            STOP:  if (decide) begin
                       if (maj) begin
                           push_req = 1'b1;
                           state_d  = IDLE;
                       end else begin
                           ferr_d  = 1'b1;
                           state_d = BRK;
                       end
                   end
            BRK:   if (s2_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Bit timing restarts from zero on every start edge
        if (state_q == IDLE || state_d == IDLE) begin
            presc_d = '0;
            tcnt_d  = '0;
        end

        do_pop  = rx_valid_q & rx_if.rx_ready;
        full    = (level_q == LW'(FIFO_DEPTH));
        do_push = push_req & (~full | do_pop);
        ovr_d   = push_req & full & ~do_pop;
        wptr_d  = wptr_q + AW'(do_push);
        rptr_d  = rptr_q + AW'(do_pop);
        level_d = level_q + LW'(do_push) - LW'(do_pop);
        remain  = level_q - LW'(do_pop);
        // Head register: bypass the incoming byte when the FIFO would otherwise be empty
        rx_data_d = rx_data_q;
        if (remain == '0 && do_push) rx_data_d = shift_q;
        else if (remain != '0)       rx_data_d = mem[rptr_d];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q       <= 1'b1;
            s2_q       <= 1'b1;
            prev_q     <= 1'b1;
            warm_q     <= '0;
            armed_q    <= 1'b0;
            state_q    <= IDLE;
            presc_q    <= '0;
            tcnt_q     <= '0;
            bit_q      <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            level_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            ferr_q     <= 1'b0;
            ovr_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            s1_q       <= rx232;
            s2_q       <= s1_q;
            prev_q     <= s2_q;
            // A line held low across reset must go high before a start is accepted
            warm_q     <= {warm_q[0], 1'b1};
            armed_q    <= armed_q | (warm_q[1] & s2_q);
            state_q    <= state_d;
            presc_q    <= presc_d;
            tcnt_q     <= tcnt_d;
            bit_q      <= bit_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            level_q    <= level_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= (level_d != '0);
            ferr_q     <= ferr_d;
            ovr_q      <= ovr_d;
            busy_q     <= (state_d != IDLE);
        end
    end

    always_ff @(posedge clk) begin
        samp_q  <= samp_d;
        shift_q <= shift_d;
        if (do_push) mem[wptr_q] <= shift_q;
    end

    assign rx_if.rx_data  = rx_data_q;
    assign rx_if.rx_valid = rx_valid_q;
    assign frame_err      = ferr_q;
    assign overrun        = ovr_q;
    assign rx_busy        = busy_q;
    assign fifo_level     = level_q;
endmodule

// File: tb/tb_rs232_rx.sv
// Scoreboard bench for rs232_rx: serial frames are driven bit by bit, expected
// bytes are queued as frames are sent and matched against each handshake pop.
module tb_rs232_rx;
    localparam int CLK_HZ = 6_400_000;
    localparam int BAUD   = 100_000;
    localparam int DEPTH  = 4;
    localparam int BIT    = 64;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx = 1'b1;
    logic       frame_err, overrun, rx_busy;
    logic [2:0] fifo_level;
    logic [7:0] exp_b;
    logic [7:0] exp_q[$];
    int n_checks = 0, n_errors = 0, n_ferr = 0, n_ovr = 0, n_vld = 0;

    rs232_rx_if rif();

    rs232_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .rx232(rx), .rx_if(rif.master),
        .frame_err(frame_err), .overrun(overrun), .rx_busy(rx_busy),
        .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!reset) begin
            if (frame_err) n_ferr++;
            if (overrun) n_ovr++;
            if (rif.rx_valid) n_vld++;
            if (frame_err && overrun) begin
                n_checks++; n_errors++;
                $display("FAIL err_exclusive frame_err=1 overrun=1, required at most one");
            end
            if (rif.rx_valid && rif.rx_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL pop_unexpected got %02h, required no byte", rif.rx_data);
                end else begin
                    exp_b = exp_q.pop_front();
                    if (rif.rx_data !== exp_b) begin
                        n_errors++;
                        $display("FAIL pop_data got %02h, required %02h", rif.rx_data, exp_b);
                    end
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stopv, input int blen);
        logic [9:0] f;
        f = {stopv, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = f[i];
            repeat (blen) @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rx = 1'b0;
        reset = 1'b1;
        idle(5);
        @(negedge clk);
        n_checks++;
        if ({rif.rx_valid, rif.rx_data, frame_err, overrun, rx_busy, fifo_level} !== 15'd0) begin
            n_errors++;
            $display("FAIL reset_outputs got v=%b d=%02h fe=%b ov=%b busy=%b lvl=%0d, required all 0",
                     rif.rx_valid, rif.rx_data, frame_err, overrun, rx_busy, fifo_level);
        end
        idle(1);
        reset = 1'b0;
        idle(100);
        @(negedge clk);
        n_checks++;
        if (rx_busy !== 1'b0) begin
            n_errors++;
            $display("FAIL low_after_reset busy got %b, required 0", rx_busy);
        end
        idle(1);
        rx = 1'b1;
        idle(20);
    endtask

    task automatic test_single();
        int v0, f0, o0;
        v0 = n_vld; f0 = n_ferr; o0 = n_ovr;
        rif.rx_ready = 1'b1;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, BIT);
        rx = 1'b1;
        idle(20);
        n_checks++;
        if (n_vld - v0 !== 1) begin
            n_errors++;
            $display("FAIL single_valid_cycles got %0d, required 1", n_vld - v0);
        end
        n_checks++;
        if ((n_ferr - f0) + (n_ovr - o0) !== 0) begin
            n_errors++;
            $display("FAIL single_err_pulses got %0d, required 0", (n_ferr - f0) + (n_ovr - o0));
        end
        n_checks++;
        if (fifo_level !== 3'd0 || exp_q.size() !== 0) begin
            n_errors++;
            $display("FAIL single_drain level=%0d pending=%0d, required 0 and 0", fifo_level, exp_q.size());
        end
    endtask

    task automatic test_overrun();
        int o0;
        o0 = n_ovr;
        rif.rx_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            if (i <= 4) exp_q.push_back(8'(i));
            send_frame(8'(i), 1'b1, BIT);
            rx = 1'b1;
            idle(10);
        end
        n_checks++;
        if (fifo_level !== 3'd4) begin
            n_errors++;
            $display("FAIL overrun_level got %0d, required 4", fifo_level);
        end
        n_checks++;
        if (n_ovr - o0 !== 1) begin
            n_errors++;
            $display("FAIL overrun_pulses got %0d, required 1", n_ovr - o0);
        end
        rif.rx_ready = 1'b1;
        idle(10);
        n_checks++;
        if (fifo_level !== 3'd0 || exp_q.size() !== 0) begin
            n_errors++;
            $display("FAIL overrun_drain level=%0d pending=%0d, required 0 and 0", fifo_level, exp_q.size());
        end
    endtask

    task automatic test_glitch();
        int v0, f0;
        v0 = n_vld; f0 = n_ferr;
        rx = 1'b0;
        idle(10);
        @(negedge clk);
        n_checks++;
        if (rx_busy !== 1'b1) begin
            n_errors++;
            $display("FAIL glitch_busy_start got %b, required 1", rx_busy);
        end
        idle(10);
        rx = 1'b1;
        idle(100);
        n_checks++;
        if (rx_busy !== 1'b0 || n_vld != v0 || n_ferr != f0) begin
            n_errors++;
            $display("FAIL glitch_reject busy=%b valids=%0d ferrs=%0d, required 0 0 0",
                     rx_busy, n_vld - v0, n_ferr - f0);
        end
    endtask

    task automatic test_break();
        int v0, f0;
        v0 = n_vld; f0 = n_ferr;
        rif.rx_ready = 1'b1;
        send_frame(8'h3C, 1'b0, BIT);
        rx = 1'b0;
        idle(10 * BIT);
        @(negedge clk);
        n_checks++;
        if (n_ferr - f0 !== 1 || rx_busy !== 1'b1) begin
            n_errors++;
            $display("FAIL break_hold ferrs=%0d busy=%b, required 1 and 1", n_ferr - f0, rx_busy);
        end
        n_checks++;
        if (n_vld != v0) begin
            n_errors++;
            $display("FAIL break_no_push valids got %0d, required 0", n_vld - v0);
        end
        idle(1);
        rx = 1'b1;
        idle(20);
        exp_q.push_back(8'h55);
        send_frame(8'h55, 1'b1, BIT);
        rx = 1'b1;
        idle(20);
        n_checks++;
        if (exp_q.size() !== 0 || n_ferr - f0 !== 1) begin
            n_errors++;
            $display("FAIL break_recover pending=%0d ferrs=%0d, required 0 and 1", exp_q.size(), n_ferr - f0);
        end
    endtask

    task automatic test_full_pop();
        int o0;
        o0 = n_ovr;
        rif.rx_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(8'h11 * 8'(i + 1));
            send_frame(8'h11 * 8'(i + 1), 1'b1, BIT);
            rx = 1'b1;
            idle(10);
        end
        exp_q.push_back(8'h99);
        fork
            send_frame(8'h99, 1'b1, BIT);
            begin
                // Stop-bit decision lands 619 edges after the start bit is driven
                repeat (618) @(posedge clk);
                #1 rif.rx_ready = 1'b1;
                @(posedge clk);
                #1 rif.rx_ready = 1'b0;
            end
        join
        rx = 1'b1;
        idle(10);
        n_checks++;
        if (n_ovr - o0 !== 0 || fifo_level !== 3'd4) begin
            n_errors++;
            $display("FAIL full_pop ovr=%0d level=%0d, required 0 and 4", n_ovr - o0, fifo_level);
        end
        rif.rx_ready = 1'b1;
        idle(10);
        n_checks++;
        if (exp_q.size() !== 0) begin
            n_errors++;
            $display("FAIL full_pop_order pending got %0d, required 0", exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        rif.rx_ready = 1'b1;
        fork
            send_frame(8'hFF, 1'b1, BIT);
            begin
                repeat (5 * BIT + 32) @(posedge clk);
                #1 reset = 1'b1;
                repeat (2) @(posedge clk);
                @(negedge clk);
                n_checks++;
                if ({rif.rx_valid, rif.rx_data, frame_err, overrun, rx_busy, fifo_level} !== 15'd0) begin
                    n_errors++;
                    $display("FAIL midreset_outputs v=%b d=%02h busy=%b lvl=%0d, required all 0",
                             rif.rx_valid, rif.rx_data, rx_busy, fifo_level);
                end
                @(posedge clk);
                #1 reset = 1'b0;
            end
        join
        rx = 1'b1;
        idle(20);
        n_checks++;
        if (rx_busy !== 1'b0 || fifo_level !== 3'd0) begin
            n_errors++;
            $display("FAIL midreset_discard busy=%b level=%0d, required 0 and 0", rx_busy, fifo_level);
        end
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1, BIT);
        rx = 1'b1;
        idle(20);
        n_checks++;
        if (exp_q.size() !== 0) begin
            n_errors++;
            $display("FAIL midreset_next pending got %0d, required 0", exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [3];
        int         lens  [4];
        int         f0;
        bytes = '{8'h12, 8'hEF, 8'h7E};
        lens  = '{66, 62, 62, 66};
        f0 = n_ferr;
        rif.rx_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(bytes[i]);
            send_frame(bytes[i], 1'b1, BIT);
        end
        rx = 1'b1;
        idle(20);
        n_checks++;
        if (exp_q.size() !== 0) begin
            n_errors++;
            $display("FAIL back_to_back pending got %0d, required 0", exp_q.size());
        end
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back((i % 2 == 0) ? 8'h00 : 8'hFF);
            send_frame((i % 2 == 0) ? 8'h00 : 8'hFF, 1'b1, lens[i]);
            rx = 1'b1;
            idle(20);
        end
        n_checks++;
        if (exp_q.size() !== 0 || n_ferr != f0) begin
            n_errors++;
            $display("FAIL skew pending=%0d ferrs=%0d, required 0 and 0", exp_q.size(), n_ferr - f0);
        end
    endtask

    initial begin
        rif.rx_ready = 1'b0;
        idle(2);
        test_reset();
        test_single();
        test_overrun();
        test_glitch();
        test_break();
        test_full_pop();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
